// File: rtl/csr_timer_bank.sv
`default_nettype none
// ============================================================================
// Module   : csr_timer_bank
// Brief    : NUM_TIMERS countdown timers with TCFG/TVAL/TICLR/TID state, a
//            free-running stable counter, a freeze control and a lowest-index
//            interrupt summary.
// Revision : 1.0
// ============================================================================
module csr_timer_bank #(
  parameter int NUM_TIMERS   = 2,
  parameter int CNT_WIDTH    = 32,
  parameter int STABLE_WIDTH = 64,
  parameter int TID_BASE     = 0,
  localparam int SEL_W       = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wen_i,
  input  logic [SEL_W-1:0]        timer_sel_i,
  input  logic [1:0]              reg_sel_i,
  input  logic [CNT_WIDTH-1:0]    wdata_i,
  output logic [CNT_WIDTH-1:0]    rdata_o,
  input  logic                    freeze_i,
  output logic [NUM_TIMERS-1:0]   irq_pending_o,
  output logic                    irq_any_o,
  output logic [SEL_W-1:0]        irq_id_o,
  output logic [STABLE_WIDTH-1:0] stable_cnt_o
);

  localparam logic [1:0] c_REG_TCFG  = 2'd0;
  localparam logic [1:0] c_REG_TVAL  = 2'd1;
  localparam logic [1:0] c_REG_TICLR = 2'd2;
  localparam logic [1:0] c_REG_TID   = 2'd3;

  logic [NUM_TIMERS-1:0][CNT_WIDTH-1:0] tcfg_q, tcfg_d;
  logic [NUM_TIMERS-1:0][CNT_WIDTH-1:0] tval_q, tval_d;
  logic [NUM_TIMERS-1:0][CNT_WIDTH-1:0] tid_q, tid_d;
  logic [NUM_TIMERS-1:0]                en_q, en_d;
  logic [NUM_TIMERS-1:0]                pend_q, pend_d;
  logic [STABLE_WIDTH-1:0]              stable_q, stable_d;

  logic [NUM_TIMERS-1:0] cfg_wr;
  logic [NUM_TIMERS-1:0] clr_wr;
  logic [NUM_TIMERS-1:0] tid_wr;
  logic [NUM_TIMERS-1:0] run;

  // Out-of-range timer_sel values never match any index, so such writes drop.
  always_comb begin
    cfg_wr = '0;
    clr_wr = '0;
    tid_wr = '0;
    run    = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      cfg_wr[i] = wen_i && (timer_sel_i == SEL_W'(i)) && (reg_sel_i == c_REG_TCFG);
      clr_wr[i] = wen_i && (timer_sel_i == SEL_W'(i)) && (reg_sel_i == c_REG_TICLR)
                  && wdata_i[0];
      tid_wr[i] = wen_i && (timer_sel_i == SEL_W'(i)) && (reg_sel_i == c_REG_TID);
      run[i]    = en_q[i] && !freeze_i && !cfg_wr[i];
    end
  end

  always_comb begin
    tcfg_d   = tcfg_q;
    tval_d   = tval_q;
    tid_d    = tid_q;
    en_d     = en_q;
    pend_d   = pend_q;
    stable_d = freeze_i ? stable_q : stable_q + STABLE_WIDTH'(1);
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (clr_wr[i]) begin
        pend_d[i] = 1'b0;
      end
      if (cfg_wr[i]) begin
        tcfg_d[i] = wdata_i;
        en_d[i]   = wdata_i[0];
        tval_d[i] = {wdata_i[CNT_WIDTH-1:2], 2'b00};
      end else if (run[i]) begin
        if (tval_q[i] != '0) begin
          tval_d[i] = tval_q[i] - CNT_WIDTH'(1);
        end else begin
          // Expiry is applied after the clear so a coincident TICLR cannot lose it.
          pend_d[i] = 1'b1;
          if (tcfg_q[i][1]) begin
            tval_d[i] = {tcfg_q[i][CNT_WIDTH-1:2], 2'b00};
          end else begin
            tval_d[i] = '1;
            en_d[i]   = 1'b0;
          end
        end
      end
      if (tid_wr[i]) begin
        tid_d[i] = wdata_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcfg_q   <= '0;
      tval_q   <= '0;
      en_q     <= '0;
      pend_q   <= '0;
      stable_q <= '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
        tid_q[i] <= CNT_WIDTH'(TID_BASE + i);
      end
    end else begin
      tcfg_q   <= tcfg_d;
      tval_q   <= tval_d;
      tid_q    <= tid_d;
      en_q     <= en_d;
      pend_q   <= pend_d;
      stable_q <= stable_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (timer_sel_i == SEL_W'(i)) begin
        case (reg_sel_i)
          c_REG_TCFG:  rdata_o = tcfg_q[i];
          c_REG_TVAL:  rdata_o = tval_q[i];
          c_REG_TID:   rdata_o = tid_q[i];
          default:     rdata_o = '0;
        endcase
      end
    end
  end

  always_comb begin
    irq_id_o = '0;
    for (int i = NUM_TIMERS - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        irq_id_o = SEL_W'(i);
      end
    end
  end

  assign irq_pending_o = pend_q;
  assign irq_any_o     = |pend_q;
  assign stable_cnt_o  = stable_q;

endmodule
`default_nettype wire
